// File: rtl/GLOBAL_PARAM.sv
// GLOBAL_PARAM: shared widths, dbuf mode encoding and the bw() width helper.
package GLOBAL_PARAM;
   localparam int DDR_W = 64;
   localparam int DBUF_GRP = 4;
   typedef enum logic {DBUF_MODE_CONV, DBUF_MODE_FC} dbuf_mode_t;
   function automatic int bw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/ddr2dbuf_addr_gen.sv
// ddr2dbuf_addr_gen: ch/pix/row beat counters producing dbuf address, unit index and last flag.
module ddr2dbuf_addr_gen
   import GLOBAL_PARAM::*;
#(
   parameter int CNT_W = 4,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              fire,
   input  dbuf_mode_t        mode,
   input  logic [CNT_W-1:0]  ch_num,
   input  logic [CNT_W-1:0]  row_num,
   input  logic [CNT_W-1:0]  pix_num,
   output logic [ADDR_W-1:0] addr,
   output logic [1:0]        unit,
   output logic              last
);
   localparam int FULL_W = 3 * CNT_W - 2;
   logic [CNT_W-1:0] ch, row, pix;
   logic [FULL_W-1:0] conv_addr;
   logic conv, ch_end, pix_end, row_end;
   assign conv = mode == DBUF_MODE_CONV;
   assign ch_end = ch == ch_num;
   assign pix_end = pix == pix_num;
   assign row_end = row == row_num;
   // ch takes the MSBs so truncation drops high channel bits first
   assign conv_addr = {ch, row[CNT_W-1:1], pix[CNT_W-1:1]};
   assign addr = conv ? ADDR_W'(conv_addr) : ADDR_W'(ch);
   assign unit = {row[0], pix[0]};
   assign last = conv ? ch_end & pix_end & row_end : ch_end;
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         ch <= '0;
         pix <= '0;
         row <= '0;
      end else if (fire) begin
         ch <= ch_end ? '0 : ch + 1'b1;
         if (conv && ch_end) begin
            pix <= pix_end ? '0 : pix + 1'b1;
            if (pix_end) row <= row_end ? '0 : row + 1'b1;
         end
      end
   end
endmodule

// File: rtl/ddr2dbuf_stream.sv
// ddr2dbuf_stream: scatters DDR beats into PE dbuf write ports with ready/valid backpressure.
// Depool mask path and paired ddr1/ddr2 handshake exist only when DDR2DBUF_DEPOOL_EN is defined.
module ddr2dbuf_stream #(
   parameter int DDR_W = GLOBAL_PARAM::DDR_W,
   parameter int DATA_W = 16,
   parameter int BATCH = 4,
   parameter int GRP = GLOBAL_PARAM::DBUF_GRP,
   parameter int PE_NUM = 32,
   parameter int BUF_DEPTH = 256,
   parameter int ADDR_W = GLOBAL_PARAM::bw(BUF_DEPTH),
   parameter int CNT_W = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               start,
   output logic                               done,
   input  logic [1:0]                         conf_mode,
   input  logic [CNT_W-1:0]                   conf_ch_num,
   input  logic [CNT_W-1:0]                   conf_row_num,
   input  logic [CNT_W-1:0]                   conf_pix_num,
   input  logic [PE_NUM-1:0]                  conf_mask,
   input  logic                               conf_depool,
   input  logic [DDR_W-1:0]                   ddr1_data,
   input  logic                               ddr1_valid,
   output logic                               ddr1_ready,
   input  logic [DDR_W-1:0]                   ddr2_data,
   input  logic                               ddr2_valid,
   output logic                               ddr2_ready,
   output logic [GRP-1:0][BATCH*DATA_W-1:0]   dbuf_wr_data,
   output logic [ADDR_W-1:0]                  dbuf_wr_addr,
   output logic [PE_NUM-1:0]                  dbuf_wr_en
);
   localparam int WORD_W = BATCH * DATA_W;
   localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2;
   logic [1:0] state;
   logic drain_cnt, run, paired, both, fire, last, depool_q, unused;
   GLOBAL_PARAM::dbuf_mode_t mode_q;
   logic [CNT_W-1:0] ch_q, row_q, pix_q;
   logic [PE_NUM-1:0] mask_q, en_c, s1_en;
   logic [ADDR_W-1:0] addr, s1_addr;
   logic [1:0] unit;
   logic [GRP-1:0] onehot;
   logic [WORD_W-1:0] word;
   logic [GRP-1:0][WORD_W-1:0] data_c, s1_data;
   assign run = state == S_RUN;
   assign done = state == S_IDLE;
   assign both = ddr1_valid & ddr2_valid;
   assign ddr1_ready = run & (~paired | both);
   assign ddr2_ready = run & paired & both;
   assign fire = ddr1_valid & ddr1_ready;
   assign word = ddr1_data[WORD_W-1:0];
   assign onehot = GRP'(1) << unit;
   assign unused = ^{ddr1_data, ddr2_data, ddr2_valid, depool_q};
`ifdef DDR2DBUF_DEPOOL_EN
   assign paired = mode_q == GLOBAL_PARAM::DBUF_MODE_CONV && depool_q;
   for (genvar j = 0; j < GRP; j++) begin : g_unit
      for (genvar i = 0; i < BATCH; i++) begin : g_elem
         assign data_c[j][i*DATA_W +: DATA_W] =
            (!paired || ddr2_data[j*BATCH+i]) ? word[i*DATA_W +: DATA_W] : '0;
      end
   end
`else
   assign paired = 1'b0;
   assign data_c = {GRP{word}};
`endif
   // plain CONV writes one unit per group; FC and depool write every masked PE
   always_comb
      en_c = !fire ? '0 :
             (mode_q == GLOBAL_PARAM::DBUF_MODE_CONV && !paired) ? mask_q & {(PE_NUM/GRP){onehot}} :
             mask_q;
   ddr2dbuf_addr_gen #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) u_addr_gen (
      .clk(clk), .rst(rst), .clear(done && start), .fire(fire), .mode(mode_q),
      .ch_num(ch_q), .row_num(row_q), .pix_num(pix_q),
      .addr(addr), .unit(unit), .last(last)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         drain_cnt <= 1'b0;
      end else begin
         drain_cnt <= state == S_DRAIN ? ~drain_cnt : 1'b0;
         state <= (done && start) ? S_RUN :
                  (fire && last) ? S_DRAIN :
                  (state == S_DRAIN && drain_cnt) ? S_IDLE : state;
      end
   end
   always_ff @(posedge clk) begin
      if (done && start) begin
         mode_q <= conf_mode == 2'd0 ? GLOBAL_PARAM::DBUF_MODE_CONV : GLOBAL_PARAM::DBUF_MODE_FC;
         ch_q <= conf_ch_num;
         row_q <= conf_row_num;
         pix_q <= conf_pix_num;
         mask_q <= conf_mask;
         depool_q <= conf_depool;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_en <= '0;
         dbuf_wr_en <= '0;
      end else begin
         s1_en <= en_c;
         dbuf_wr_en <= s1_en;
      end
   end
   always_ff @(posedge clk) begin
      s1_data <= data_c;
      s1_addr <= addr;
      dbuf_wr_data <= s1_data;
      dbuf_wr_addr <= s1_addr;
   end
endmodule

// File: tb/tb_ddr2dbuf_stream.sv
// tb_ddr2dbuf_stream: randomized beat streams checked against a per-beat arithmetic model.
module tb_ddr2dbuf_stream;
`ifdef DDR2DBUF_DEPOOL_EN
   localparam bit DEPOOL_ON = 1'b1;
`else
   localparam bit DEPOOL_ON = 1'b0;
`endif
   logic clk = 1'b0, rst, start, conf_depool, ddr1_valid, ddr2_valid;
   logic done, ddr1_ready, ddr2_ready;
   logic [1:0] conf_mode;
   logic [3:0] conf_ch_num, conf_row_num, conf_pix_num;
   logic [31:0] conf_mask, dbuf_wr_en;
   logic [63:0] ddr1_data, ddr2_data;
   logic [3:0][63:0] dbuf_wr_data;
   logic [7:0] dbuf_wr_addr;
   int pass_cnt = 0, fail_cnt = 0, total = 0, cyc = 0;
   typedef struct {
      int cyc;
      logic [7:0] addr;
      logic [31:0] en;
      logic [3:0][63:0] data;
   } wr_t;
   wr_t exp_q[$];

   always #5 clk = ~clk;

   ddr2dbuf_stream dut (
      .clk(clk), .rst(rst), .start(start), .done(done),
      .conf_mode(conf_mode), .conf_ch_num(conf_ch_num), .conf_row_num(conf_row_num),
      .conf_pix_num(conf_pix_num), .conf_mask(conf_mask), .conf_depool(conf_depool),
      .ddr1_data(ddr1_data), .ddr1_valid(ddr1_valid), .ddr1_ready(ddr1_ready),
      .ddr2_data(ddr2_data), .ddr2_valid(ddr2_valid), .ddr2_ready(ddr2_ready),
      .dbuf_wr_data(dbuf_wr_data), .dbuf_wr_addr(dbuf_wr_addr), .dbuf_wr_en(dbuf_wr_en)
   );

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Expected write for the k-th beat of a transfer, from the loop-order rules
   function automatic wr_t beat_exp(input int k, input bit conv, input bit paired, input int c,
                                    input int r, input int p, input logic [31:0] mask,
                                    input logic [63:0] d1, input logic [63:0] dm, input int when);
      wr_t w;
      int ci, pi, ri, u;
      w.cyc = when;
      if (conv) begin
         ci = k % (c + 1);
         pi = (k / (c + 1)) % (p + 1);
         ri = (k / ((c + 1) * (p + 1))) % (r + 1);
         u = (ri % 2) * 2 + pi % 2;
         w.addr = 8'((ci * 64 + (ri / 2) * 8 + pi / 2) % 256);
         w.en = paired ? mask : mask & (32'h1111_1111 << u);
      end else begin
         w.addr = 8'(k % 256);
         w.en = mask;
      end
      for (int j = 0; j < 4; j++)
         for (int e = 0; e < 4; e++)
            w.data[j][e*16 +: 16] = (!paired || dm[j*4+e]) ? d1[e*16 +: 16] : 16'h0;
      return w;
   endfunction

   task automatic check_out();
      wr_t w;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
         w = exp_q.pop_front();
         chk("wr_en", dbuf_wr_en, w.en);
         chk("wr_addr", dbuf_wr_addr, w.addr);
         chk("wr_data", dbuf_wr_data, w.data);
      end else chk("wr_idle", dbuf_wr_en, 0);
   endtask

   task automatic xfer(input logic [1:0] mode, input int c, input int r, input int p,
                       input logic [31:0] mask, input logic dp, input int pv, input int d2,
                       input bit fix2, input logic [63:0] m2, input bit restart);
      bit conv, paired, rs_done, run, fire, e_r1, e_r2;
      int n, k, last, waitc, iter;
      logic [63:0] d1, dm;
      conv = (mode == 2'd0);
      paired = DEPOOL_ON && conv && dp;
      n = conv ? (c + 1) * (p + 1) * (r + 1) : c + 1;
      k = 0; last = -1; waitc = 0; iter = 0; rs_done = 0;
      @(negedge clk); cyc++;
      conf_mode = mode; conf_ch_num = 4'(c); conf_row_num = 4'(r); conf_pix_num = 4'(p);
      conf_mask = mask; conf_depool = dp; start = 1'b1; ddr1_valid = 1'b0; ddr2_valid = 1'b0;
      #1;
      check_out();
      chk("start_done", done, 1'b1);
      chk("start_ready", {ddr1_ready, ddr2_ready}, 2'b00);
      d1 = {$urandom, $urandom};
      dm = fix2 ? m2 : {$urandom, $urandom};
      while (last < 0 || cyc < last + 3) begin
         @(negedge clk); cyc++; iter++;
         start = 1'b0;
         if (restart && k == 2 && !rs_done) begin
            start = 1'b1; rs_done = 1'b1;
            conf_mode = ~mode; conf_ch_num = ~conf_ch_num; conf_mask = ~mask;
         end
         run = (k < n);
         if (paired && run) begin
            ddr1_valid = 1'b1;
            ddr2_valid = (waitc >= d2);
         end else begin
            ddr1_valid = ($urandom_range(99) < pv);
            ddr2_valid = 1'($urandom_range(1));
            if (!paired) begin
               d1 = {$urandom, $urandom};
               dm = fix2 ? m2 : {$urandom, $urandom};
            end
         end
         ddr1_data = d1; ddr2_data = dm;
         #1;
         check_out();
         chk("done", done, last >= 0 && cyc >= last + 3);
         e_r1 = run && (!paired || (ddr1_valid && ddr2_valid));
         e_r2 = run && paired && ddr1_valid && ddr2_valid;
         chk("ddr1_ready", ddr1_ready, e_r1);
         chk("ddr2_ready", ddr2_ready, e_r2);
         fire = e_r1 && ddr1_valid;
         if (fire) begin
            exp_q.push_back(beat_exp(k, conv, paired, c, r, p, mask, d1, dm, cyc + 2));
            k++; waitc = 0;
            if (k == n) last = cyc;
            d1 = {$urandom, $urandom};
            dm = fix2 ? m2 : {$urandom, $urandom};
         end else if (run) waitc++;
         if (iter > 3000) begin
            chk("timeout_beats", k, n);
            break;
         end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; conf_mode = 2'd0; conf_ch_num = '0; conf_row_num = '0;
      conf_pix_num = '0; conf_mask = '0; conf_depool = 1'b0; ddr1_valid = 1'b1;
      ddr2_valid = 1'b1; ddr1_data = '0; ddr2_data = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_done", done, 1'b1);
      chk("rst_ready", {ddr1_ready, ddr2_ready}, 2'b00);
      chk("rst_wr_en", dbuf_wr_en, 32'h0);
      rst = 1'b0;
      // FC, 8 beats always valid
      xfer(2'd1, 7, 0, 0, 32'h0000_000F, 1'b0, 100, 0, 1'b0, 64'h0, 1'b0);
      // CONV 2x2x2 without depool
      xfer(2'd0, 1, 1, 1, $urandom, 1'b0, 100, 0, 1'b0, 64'h0, 1'b0);
      // single-beat degenerate transfers
      xfer(2'd0, 0, 0, 0, $urandom, 1'b0, 100, 0, 1'b0, 64'h0, 1'b0);
      xfer(2'd1, 0, 0, 0, $urandom, 1'b0, 50, 0, 1'b0, 64'h0, 1'b0);
      // reserved mode behaves as FC; start during RUN ignored
      xfer(2'd3, 9, 0, 0, $urandom, 1'b0, 50, 0, 1'b0, 64'h0, 1'b1);
      for (int t = 0; t < 4; t++)
         xfer(2'd0, $urandom_range(3), $urandom_range(3), $urandom_range(3), $urandom,
              1'b0, 50, 0, 1'b0, 64'h0, t[0]);
      // depool: ddr2 valid two cycles after ddr1, fixed mask keeps unit 1 only
      xfer(2'd0, 1, 1, 1, 32'hFFFF_FFFF, 1'b1, 100, 2, 1'b1, 64'h0000_0000_0000_00F0, 1'b0);
      xfer(2'd0, $urandom_range(3), $urandom_range(3), $urandom_range(3), $urandom,
           1'b1, 50, $urandom_range(3), 1'b0, 64'h0, 1'b0);
      // reset during RUN aborts, no strobe afterwards
      @(negedge clk);
      conf_mode = 2'd1; conf_ch_num = 4'd15; conf_mask = 32'hFFFF_FFFF; start = 1'b1;
      ddr1_valid = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      #1;
      chk("abort_wr_en", dbuf_wr_en, 32'h0);
      chk("abort_done", done, 1'b1);
      chk("abort_ready", {ddr1_ready, ddr2_ready}, 2'b00);
      @(negedge clk);
      #1;
      chk("abort_wr_en2", dbuf_wr_en, 32'h0);
      xfer(2'd1, 5, 0, 0, $urandom, 1'b0, 50, 0, 1'b0, 64'h0, 1'b0);
      xfer(2'd0, 2, 1, 2, $urandom, 1'b0, 50, 0, 1'b0, 64'h0, 1'b0);
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
